// File: rtl/pixel_shadow_map.sv
// pixel_shadow_map: snoops draw-engine pixel writes into a 160x120x3 shadow RAM and answers rectangle collision queries.
// Optional macro SHADOW_CLEAR_EN: after every reset, clear the shadow RAM to BG_COLOUR before accepting queries.
module pixel_shadow_map #(
  parameter int         H_RES     = 160,
  parameter int         V_RES     = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         SPAN_W    = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              plot,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [2:0]        colour,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [7:0]        q_x,
  input  logic [6:0]        q_y,
  input  logic [SPAN_W-1:0] q_w,
  input  logic [SPAN_W-1:0] q_h,
  input  logic [2:0]        q_ignore,
  output logic              r_valid,
  output logic              r_hit,
  output logic [7:0]        r_hit_x,
  output logic [6:0]        r_hit_y,
  output logic              busy
);
  localparam int DEPTH = H_RES * V_RES;

  typedef enum logic [1:0] {CLEAR, IDLE, SCAN, DONE} state_t;
`ifdef SHADOW_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state_reg, state_next;
  logic [14:0]       clr_addr_reg, clr_addr_next;
  logic [7:0]        qx_reg, qx_next;
  logic [6:0]        qy_reg, qy_next;
  logic [SPAN_W-1:0] qw_reg, qw_next, qh_reg, qh_next;
  logic [2:0]        ign_reg, ign_next;
  logic [8:0]        px_reg, px_next;
  logic [7:0]        py_reg, py_next;
  logic              issued_all_reg, issued_all_next;
  logic              rd_valid_reg, rd_valid_next;
  logic [7:0]        rd_x_reg, rd_x_next;
  logic [6:0]        rd_y_reg, rd_y_next;
  logic              hit_reg, hit_next;
  logic [7:0]        hit_x_reg, hit_x_next;
  logic [6:0]        hit_y_reg, hit_y_next;
  logic              q_ready_reg, q_ready_next;

  logic [2:0]  mem [DEPTH];
  logic [2:0]  ram_q;
  logic        ram_we, ram_re;
  logic [14:0] ram_addr;
  logic [2:0]  ram_wdata;

  // Pointer sums are one bit wider than the coordinates so the far edge never wraps.
  logic [8:0]  x_end;
  logic [7:0]  y_end;
  logic        plot_ok, ptr_in_range, scan_hit, scan_issue;
  logic [14:0] plot_addr, scan_addr;

  assign x_end        = {1'b0, qx_reg} + 9'(qw_reg) - 9'd1;
  assign y_end        = {1'b0, qy_reg} + 8'(qh_reg) - 8'd1;
  assign plot_ok      = plot && (x < 8'(H_RES)) && (y < 7'(V_RES));
  assign ptr_in_range = (px_reg < 9'(H_RES)) && (py_reg < 8'(V_RES));
  assign plot_addr    = 15'(y) * 15'(H_RES) + 15'(x);
  assign scan_addr    = 15'(py_reg[6:0]) * 15'(H_RES) + 15'(px_reg[7:0]);
  assign scan_hit     = rd_valid_reg && (ram_q != BG_COLOUR) && (ram_q != ign_reg);
  // A pixel write owns the RAM port for its cycle, so the scan pointer simply waits.
  assign scan_issue   = (state_reg == SCAN) && !issued_all_reg && !plot_ok && !scan_hit;
  assign ram_re       = scan_issue && ptr_in_range;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = scan_addr;
    ram_wdata = colour;
    if (state_reg == CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr_reg;
      ram_wdata = BG_COLOUR;
    end else if (plot_ok) begin
      ram_we   = 1'b1;
      ram_addr = plot_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  always_comb begin
    state_next      = state_reg;
    clr_addr_next   = clr_addr_reg;
    qx_next         = qx_reg;
    qy_next         = qy_reg;
    qw_next         = qw_reg;
    qh_next         = qh_reg;
    ign_next        = ign_reg;
    px_next         = px_reg;
    py_next         = py_reg;
    issued_all_next = issued_all_reg;
    rd_valid_next   = 1'b0;
    rd_x_next       = rd_x_reg;
    rd_y_next       = rd_y_reg;
    hit_next        = hit_reg;
    hit_x_next      = hit_x_reg;
    hit_y_next      = hit_y_reg;
    case (state_reg)
      CLEAR: begin
        clr_addr_next = clr_addr_reg + 15'd1;
        if (clr_addr_reg == 15'(DEPTH - 1)) begin
          clr_addr_next = '0;
          state_next    = IDLE;
        end
      end
      IDLE: begin
        if (q_valid && q_ready_reg) begin
          qx_next         = q_x;
          qy_next         = q_y;
          qw_next         = q_w;
          qh_next         = q_h;
          ign_next        = q_ignore;
          px_next         = {1'b0, q_x};
          py_next         = {1'b0, q_y};
          issued_all_next = 1'b0;
          if (q_w == '0 || q_h == '0) begin
            hit_next   = 1'b0;
            hit_x_next = '0;
            hit_y_next = '0;
            state_next = DONE;
          end else begin
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (scan_hit) begin
          hit_next   = 1'b1;
          hit_x_next = rd_x_reg;
          hit_y_next = rd_y_reg;
          state_next = DONE;
        end else if (issued_all_reg) begin
          hit_next   = 1'b0;
          hit_x_next = '0;
          hit_y_next = '0;
          state_next = DONE;
        end else if (scan_issue) begin
          rd_valid_next = ptr_in_range;
          rd_x_next     = px_reg[7:0];
          rd_y_next     = py_reg[6:0];
          if (px_reg == x_end) begin
            px_next = {1'b0, qx_reg};
            if (py_reg == y_end) issued_all_next = 1'b1;
            else                 py_next = py_reg + 8'd1;
          end else begin
            px_next = px_reg + 9'd1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = RESET_STATE;
    endcase
    q_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= RESET_STATE;
      clr_addr_reg   <= '0;
      qx_reg         <= '0;
      qy_reg         <= '0;
      qw_reg         <= '0;
      qh_reg         <= '0;
      ign_reg        <= '0;
      px_reg         <= '0;
      py_reg         <= '0;
      issued_all_reg <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_x_reg       <= '0;
      rd_y_reg       <= '0;
      hit_reg        <= 1'b0;
      hit_x_reg      <= '0;
      hit_y_reg      <= '0;
      q_ready_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_addr_reg   <= clr_addr_next;
      qx_reg         <= qx_next;
      qy_reg         <= qy_next;
      qw_reg         <= qw_next;
      qh_reg         <= qh_next;
      ign_reg        <= ign_next;
      px_reg         <= px_next;
      py_reg         <= py_next;
      issued_all_reg <= issued_all_next;
      rd_valid_reg   <= rd_valid_next;
      rd_x_reg       <= rd_x_next;
      rd_y_reg       <= rd_y_next;
      hit_reg        <= hit_next;
      hit_x_reg      <= hit_x_next;
      hit_y_reg      <= hit_y_next;
      q_ready_reg    <= q_ready_next;
    end
  end

  assign q_ready = q_ready_reg;
  assign r_valid = (state_reg == DONE);
  assign r_hit   = hit_reg;
  assign r_hit_x = hit_x_reg;
  assign r_hit_y = hit_y_reg;
  assign busy    = (state_reg == CLEAR) || (state_reg == SCAN);
endmodule

// File: tb/tb_pixel_shadow_map.sv
// Directed bench for pixel_shadow_map: pixel writes, rectangle queries, write stalls and mid-scan reset.
module tb_pixel_shadow_map;
  logic       clk = 1'b0, resetn = 1'b0, plot = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       q_valid = 1'b0, q_ready;
  logic [7:0] q_x = '0;
  logic [6:0] q_y = '0;
  logic [4:0] q_w = '0, q_h = '0;
  logic [2:0] q_ignore = '0;
  logic       r_valid, r_hit, busy;
  logic [7:0] r_hit_x;
  logic [6:0] r_hit_y;

  int   n_checks = 0, n_fail = 0;
  int   lat, hx, hy, edges;
  logic hit, busy1, valid_after, seen;

`ifdef SHADOW_CLEAR_EN
  localparam int   READY_EDGES = 19200;
  localparam logic BUSY_RST    = 1'b1;
`else
  localparam int   READY_EDGES = 1;
  localparam logic BUSY_RST    = 1'b0;
`endif

  always #5 clk = ~clk;

  pixel_shadow_map dut (
    .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
    .q_valid(q_valid), .q_ready(q_ready), .q_x(q_x), .q_y(q_y), .q_w(q_w), .q_h(q_h),
    .q_ignore(q_ignore), .r_valid(r_valid), .r_hit(r_hit), .r_hit_x(r_hit_x),
    .r_hit_y(r_hit_y), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_q_ready"}, 32'(q_ready), 0);
    chk({tag, "_r_valid"}, 32'(r_valid), 0);
    chk({tag, "_r_hit"},   32'(r_hit), 0);
    chk({tag, "_r_hit_x"}, 32'(r_hit_x), 0);
    chk({tag, "_r_hit_y"}, 32'(r_hit_y), 0);
    chk({tag, "_busy"},    32'(busy), 32'(BUSY_RST));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 25000; i++) begin
      @(posedge clk); #1;
      n++;
      if (q_ready) break;
    end
  endtask

  task automatic plot_px(input int px, input int py, input int pc);
    @(negedge clk);
    plot = 1'b1; x = 8'(px); y = 7'(py); colour = 3'(pc);
    @(negedge clk);
    plot = 1'b0;
  endtask

  // Issues one query; optionally injects a pixel write during cycle inj after accept.
  task automatic run_query(input int qx, input int qy, input int qw, input int qh, input int ign,
                           input int inj, input int ix, input int iy, input int ic);
    lat = -1; hit = 1'bx; hx = -1; hy = -1; busy1 = 1'bx;
    @(negedge clk);
    chk("q_ready_idle", 32'(q_ready), 1);
    q_valid = 1'b1; q_x = 8'(qx); q_y = 7'(qy); q_w = 5'(qw); q_h = 5'(qh); q_ignore = 3'(ign);
    @(posedge clk); #1;
    q_valid = 1'b0; q_x = 8'hff; q_y = 7'h7f; q_w = 5'd31; q_h = 5'd31; q_ignore = 3'd7;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == inj) begin plot = 1'b1; x = 8'(ix); y = 7'(iy); colour = 3'(ic); end
      if (k == inj + 1) plot = 1'b0;
      if (k == 1) busy1 = busy;
      if (r_valid) begin
        lat = k; hit = r_hit; hx = int'(r_hit_x); hy = int'(r_hit_y);
        break;
      end
    end
    plot = 1'b0;
    @(negedge clk);
    valid_after = r_valid;
  endtask

  task automatic expect_result(input string tag, input int elat, input logic ehit,
                               input int ex, input int ey);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_hit"}, 32'(hit), 32'(ehit));
    chk({tag, "_hit_x"}, 32'(hx), 32'(ex));
    chk({tag, "_hit_y"}, 32'(hy), 32'(ey));
    chk({tag, "_one_cycle"}, 32'(valid_after), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_check("reset");
    resetn = 1'b1;
    wait_ready(edges);
    chk("ready_edges", 32'(edges), 32'(READY_EDGES));
    chk("busy_after_ready", 32'(busy), 0);

    run_query(0, 0, 31, 31, 0, 0, 0, 0, 0);
    expect_result("empty_31x31", 963, 1'b0, 0, 0);

    plot_px(50, 40, 4);
    run_query(45, 35, 10, 10, 0, 0, 0, 0, 0);
    expect_result("hit_50_40", 58, 1'b1, 50, 40);
    chk("busy_in_scan", 32'(busy1), 1);

    run_query(45, 35, 10, 10, 4, 0, 0, 0, 0);
    expect_result("ignored_colour", 102, 1'b0, 0, 0);

    plot_px(200, 5, 7);
    plot_px(0, 116, 2);
    run_query(155, 115, 10, 10, 0, 0, 0, 0, 0);
    expect_result("edge_region", 102, 1'b0, 0, 0);
    run_query(40, 6, 1, 1, 0, 0, 0, 0, 0);
    expect_result("oor_plot_dropped", 3, 1'b0, 0, 0);
    run_query(0, 116, 1, 1, 0, 0, 0, 0, 0);
    expect_result("single_pixel_hit", 3, 1'b1, 0, 116);

    run_query(10, 10, 0, 5, 0, 0, 0, 0, 0);
    expect_result("zero_width", 1, 1'b0, 0, 0);
    chk("zero_width_busy", 32'(busy1), 0);
    run_query(10, 10, 5, 0, 0, 0, 0, 0, 0);
    expect_result("zero_height", 1, 1'b0, 0, 0);

    run_query(0, 0, 4, 4, 0, 3, 3, 3, 2);
    expect_result("stall_write", 19, 1'b1, 3, 3);

    @(negedge clk);
    q_valid = 1'b1; q_x = 8'd0; q_y = 7'd0; q_w = 5'd31; q_h = 5'd31; q_ignore = 3'd0;
    @(posedge clk); #1;
    q_valid = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); seen |= r_valid; end
    resetn = 1'b0;
    #1;
    reset_check("midscan_reset");
    chk("no_rvalid_before_reset", 32'(seen), 0);
    repeat (3) begin @(negedge clk); seen |= r_valid; end
    chk("no_rvalid_in_reset", 32'(seen), 0);
    resetn = 1'b1;
    wait_ready(edges);
    chk("ready_edges_again", 32'(edges), 32'(READY_EDGES));

    run_query(45, 35, 10, 10, 0, 0, 0, 0, 0);
`ifdef SHADOW_CLEAR_EN
    expect_result("after_reset_cleared", 102, 1'b0, 0, 0);
`else
    expect_result("after_reset_kept", 58, 1'b1, 50, 40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pixel_shadow_map.md
Name: pixel_shadow_map

Overview:
- Responder on the pixel-write interface that the draw engine drives into the VGA adapter (x, y, colour, plot).
- Snoops every pixel write into an internal 160x120x3 shadow framebuffer.
- Answers rectangle collision queries from the game control logic over a valid/ready request channel and a one-cycle result pulse.
- Sits beside the VGA adapter and shares the draw engine's x, y, colour and plot nets.

Parameters:
- H_RES, 160, horizontal pixel count; x >= H_RES is out of range.
- V_RES, 120, vertical pixel count; y >= V_RES is out of range.
- BG_COLOUR, 3'b000, background colour; never reported as a hit.
- SPAN_W, 5, width of the q_w and q_h span fields (spans 0..31).

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- plot  in  1  pixel write strobe from the draw engine
- x  in  8  write x coordinate
- y  in  7  write y coordinate
- colour  in  3  write colour
- q_valid  in  1  query request valid
- q_ready  out  1  query accepted when q_valid and q_ready are both high
- q_x  in  8  rectangle left edge
- q_y  in  7  rectangle top edge
- q_w  in  SPAN_W  rectangle width in pixels
- q_h  in  SPAN_W  rectangle height in pixels
- q_ignore  in  3  colour excluded from hits (the querying object's own colour)
- r_valid  out  1  one-cycle result strobe
- r_hit  out  1  1 = some pixel in the rectangle is neither BG_COLOUR nor q_ignore
- r_hit_x  out  8  x of the first hit pixel in raster order; 0 on a miss
- r_hit_y  out  7  y of the first hit pixel in raster order; 0 on a miss
- busy  out  1  high in CLEAR and SCAN

Behaviour:
- Storage: single-port synchronous RAM, 19200 x 3 bits, addressed as y*H_RES + x (15 bits), one-cycle read latency.
- Reset values: q_ready=0, r_valid=0, r_hit=0, r_hit_x=0, r_hit_y=0, busy=1 (with SHADOW_CLEAR_EN). Query registers are cleared.
- FSM states: CLEAR, IDLE, SCAN, DONE.
- CLEAR:
  - Writes BG_COLOUR to addresses 0..19199, one per cycle, then moves to IDLE. Takes 19200 cycles.
  - Plot writes arriving during CLEAR are dropped.
- IDLE:
  - q_ready=1.
  - On accept: latch q_x, q_y, q_w, q_h, q_ignore.
  - If q_w=0 or q_h=0, go to DONE (miss). Otherwise go to SCAN with the scan pointer at (q_x, q_y).
- SCAN:
  - Walks the rectangle in raster order: x increments; at q_x+q_w-1, x wraps to q_x and y increments.
  - Each read's data is compared one cycle later.
  - Pixels with x >= H_RES or y >= V_RES are not read and count as background. Sums are computed at 9/8 bits, so there is no coordinate wrap.
  - Stops on the first hit (pipelined reads already issued are discarded) or after the last pixel's compare. Then goes to DONE.
- DONE: r_valid=1 for exactly one cycle, with r_hit, r_hit_x and r_hit_y valid in the same cycle. Next state is IDLE.
- Write priority:
  - In IDLE, SCAN and DONE, plot with an in-range coordinate writes colour at the next clk edge.
  - A write cycle steals the RAM port. The scan pointer holds, and no compare is issued for that slot.
  - Out-of-range plot is ignored.
- Latency with no write interference: miss = q_w*q_h + 2 cycles from accept to r_valid; a zero span gives r_valid 1 cycle after accept.
- Write/scan ordering: a write to a pixel not yet read is visible to the scan; a write to an already-read pixel is not.
- q_ready=0 in every state except IDLE. Query inputs are sampled only at accept, so changing them mid-scan has no effect.
- resetn asserted mid-scan aborts the scan immediately, with no r_valid, and returns to CLEAR (or IDLE without the macro).

Optional Feature:
- Macro: SHADOW_CLEAR_EN.
- Defined: reset enters CLEAR as described; busy=1 until the clear completes.
- Undefined: the RAM is initialised to BG_COLOUR at configuration only. Reset enters IDLE directly, with busy=0 and q_ready=1 one cycle after resetn deasserts. RAM contents survive resetn.

Test Plan:
- Reset, SHADOW_CLEAR_EN defined -> busy=1 for 19200 cycles, then q_ready=1. A query (0,0,31,31,ign=0) then gives r_hit=0 after 963 cycles.
- plot (x=50, y=40, colour=3'b100), then query (45,35,10,10,ign=0) -> r_hit=1, r_hit_x=50, r_hit_y=40, r_valid exactly one cycle.
- Same pixel, query with q_ignore=3'b100 -> r_hit=0, after 10*10+2=102 cycles.
- Query (155,115,10,10) over a background-only edge region, with plot at (200,5) ignored -> r_hit=0, no RAM access outside range, r_valid after 102 cycles.
- Start a miss scan of (0,0,4,4) and inject plot (3,3,3'b010) on cycle 3 after accept -> the scan stalls one cycle and reports r_hit=1 at (3,3), r_valid at cycle 19.
- q_w=0 query -> r_valid and r_hit=0 one cycle after accept. Assert resetn low mid-scan -> no r_valid, and all outputs return to their reset values.
